// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the pipelined OTTER core: MEM/WB forwarding, load-use and
// multi-cycle scoreboard stalls, control-hazard flush and stall/flush counters.
module hazard_scoreboard_unit #(
  parameter int ADDR_W     = 5,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] de_adr1,
  input  logic [ADDR_W-1:0] de_adr2,
  input  logic              de_rs1_used,
  input  logic              de_rs2_used,
  input  logic [ADDR_W-1:0] de_rd,
  input  logic              de_regwrite,
  input  logic              de_is_mc,
  input  logic [ADDR_W-1:0] ex_adr1,
  input  logic [ADDR_W-1:0] ex_adr2,
  input  logic              ex_rs1_used,
  input  logic              ex_rs2_used,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_mc_issue,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  input  logic              mc_done,
  input  logic [1:0]        pc_source,
  output logic [1:0]        fsel1,
  output logic [1:0]        fsel2,
  output logic              STALL,
  output logic              FLUSH,
  output logic              mc_busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int TMO_W = $clog2(MC_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MC_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pend_rd;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_timeout_err;
  logic [CNT_W-1:0]  r_stall_count;
  logic [CNT_W-1:0]  r_flush_count;

  logic w_mc_active;
  logic w_lu_stall;
  logic w_raw_stall;
  logic w_waw_stall;
  logic w_str_stall;

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] adr, input logic used);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && mem_regwrite && mem_rd == adr && mem_rd != '0)
      sel = 2'b01;
    else if (used && wb_regwrite && wb_rd == adr && wb_rd != '0)
      sel = 2'b10;
    return sel;
  endfunction

  function automatic logic de_reads(input logic [ADDR_W-1:0] adr);
    return (de_rs1_used && de_adr1 == adr) || (de_rs2_used && de_adr2 == adr);
  endfunction

  assign fsel1 = fwd_sel(ex_adr1, ex_rs1_used);
  assign fsel2 = fwd_sel(ex_adr2, ex_rs2_used);

  assign mc_busy     = (r_state == S_BUSY);
  assign timeout_err = r_timeout_err;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

  // mc_done frees the scoreboard in its own cycle; the result goes via WB.
  assign w_mc_active = mc_busy && !mc_done;
  assign w_lu_stall  = ex_is_load && ex_rd != '0 && de_reads(ex_rd);
  assign w_raw_stall = w_mc_active && r_pend_rd != '0 && de_reads(r_pend_rd);
  assign w_waw_stall = w_mc_active && de_regwrite && de_rd == r_pend_rd && r_pend_rd != '0;
  assign w_str_stall = de_is_mc && (w_mc_active || ex_mc_issue);

  assign FLUSH = (pc_source != 2'b00);
  // A flushed DE instruction is dead, so it never needs to be held.
  assign STALL = (w_lu_stall || w_raw_stall || w_waw_stall || w_str_stall) && !FLUSH;

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= S_IDLE;
      r_pend_rd     <= '0;
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ex_mc_issue) begin
            r_state   <= S_BUSY;
            r_pend_rd <= ex_rd;
            r_tmo_cnt <= '0;
          end
        end
        S_BUSY: begin
          if (mc_done) begin
            r_state   <= S_IDLE;
            r_pend_rd <= '0;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_state       <= S_IDLE;
            r_pend_rd     <= '0;
            r_timeout_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (STALL && r_stall_count != '1)
        r_stall_count <= r_stall_count + 1'b1;
      if (FLUSH && r_flush_count != '1)
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench: two hazard units (timeouts 64 and 4) on shared stimulus,
// checked every cycle against a behavioural model plus directed literal checks.
module tb_hazard_scoreboard_unit;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 32;
  localparam longint CNT_MAX = (64'sd1 <<< CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [ADDR_W-1:0] de_adr1, de_adr2, de_rd, ex_adr1, ex_adr2, ex_rd, mem_rd, wb_rd;
  logic de_rs1_used, de_rs2_used, de_regwrite, de_is_mc;
  logic ex_rs1_used, ex_rs2_used, ex_is_load, ex_mc_issue;
  logic mem_regwrite, wb_regwrite, mc_done;
  logic [1:0] pc_source;

  logic [1:0]       a_fsel1, a_fsel2, b_fsel1, b_fsel2;
  logic             a_stall, a_flush, a_mc_busy, a_terr;
  logic             b_stall, b_flush, b_mc_busy, b_terr;
  logic [CNT_W-1:0] a_stall_count, a_flush_count, b_stall_count, b_flush_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  hazard_scoreboard_unit #(.ADDR_W(ADDR_W), .MC_TIMEOUT(64), .CNT_W(CNT_W)) dut_a (
    .CLK(CLK), .RST_N(RST_N),
    .de_adr1(de_adr1), .de_adr2(de_adr2), .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .de_rd(de_rd), .de_regwrite(de_regwrite), .de_is_mc(de_is_mc),
    .ex_adr1(ex_adr1), .ex_adr2(ex_adr2), .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mc_issue(ex_mc_issue),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .mc_done(mc_done), .pc_source(pc_source),
    .fsel1(a_fsel1), .fsel2(a_fsel2), .STALL(a_stall), .FLUSH(a_flush),
    .mc_busy(a_mc_busy), .timeout_err(a_terr),
    .stall_count(a_stall_count), .flush_count(a_flush_count)
  );

  hazard_scoreboard_unit #(.ADDR_W(ADDR_W), .MC_TIMEOUT(4), .CNT_W(CNT_W)) dut_b (
    .CLK(CLK), .RST_N(RST_N),
    .de_adr1(de_adr1), .de_adr2(de_adr2), .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .de_rd(de_rd), .de_regwrite(de_regwrite), .de_is_mc(de_is_mc),
    .ex_adr1(ex_adr1), .ex_adr2(ex_adr2), .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mc_issue(ex_mc_issue),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .mc_done(mc_done), .pc_source(pc_source),
    .fsel1(b_fsel1), .fsel2(b_fsel2), .STALL(b_stall), .FLUSH(b_flush),
    .mc_busy(b_mc_busy), .timeout_err(b_terr),
    .stall_count(b_stall_count), .flush_count(b_flush_count)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit     busy;
    int     pend;
    int     age;    // BUSY cycles already spent
    bit     terr;
    longint sc;
    longint fc;
  } mstate_t;

  mstate_t m [2];

  function automatic int lim(input int k);
    return (k == 0) ? 64 : 4;
  endfunction

  function automatic bit reads(input int r);
    return (de_rs1_used && int'(de_adr1) == r) || (de_rs2_used && int'(de_adr2) == r);
  endfunction

  function automatic bit exp_flush();
    return pc_source != 2'b00;
  endfunction

  function automatic bit exp_stall(input int k);
    bit holding;
    bit s;
    holding = m[k].busy && !mc_done;
    s = 1'b0;
    if (ex_is_load && ex_rd != 0 && reads(int'(ex_rd))) s = 1'b1;
    if (holding && m[k].pend != 0 &&
        (reads(m[k].pend) || (de_regwrite && int'(de_rd) == m[k].pend))) s = 1'b1;
    if (de_is_mc && (holding || ex_mc_issue)) s = 1'b1;
    return s && !exp_flush();
  endfunction

  function automatic int exp_fsel(input int adr, input bit used);
    if (!used || adr == 0) return 0;
    if (mem_regwrite && int'(mem_rd) == adr) return 1;
    if (wb_regwrite && int'(wb_rd) == adr) return 2;
    return 0;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    mstate_t n;
    for (int k = 0; k < 2; k++) begin
      if (!RST_N) begin
        n = '{busy: 1'b0, pend: 0, age: 0, terr: 1'b0, sc: 0, fc: 0};
      end else begin
        n = m[k];
        if (exp_stall(k) && n.sc < CNT_MAX) n.sc = n.sc + 1;
        if (exp_flush() && n.fc < CNT_MAX) n.fc = n.fc + 1;
        if (n.busy) begin
          if (mc_done) begin
            n.busy = 1'b0;
          end else begin
            n.age = n.age + 1;
            if (n.age == lim(k)) begin
              n.busy = 1'b0;
              n.terr = 1'b1;
            end
          end
        end else if (ex_mc_issue) begin
          n.busy = 1'b1;
          n.pend = int'(ex_rd);
          n.age  = 0;
        end
      end
      m[k] <= n;
    end
  end

  always @(posedge CLK)
    if (RST_N)
      assert (!(m[0].busy && mc_done && ex_mc_issue))
        else $error("mc issue coincided with mc completion");

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both units against the model.
  always @(negedge CLK) begin
    if (RST_N) begin
      check("m_fsel1", a_fsel1, exp_fsel(int'(ex_adr1), ex_rs1_used));
      check("m_fsel2", a_fsel2, exp_fsel(int'(ex_adr2), ex_rs2_used));
      check("m_b_fsel1", b_fsel1, exp_fsel(int'(ex_adr1), ex_rs1_used));
      check("m_b_fsel2", b_fsel2, exp_fsel(int'(ex_adr2), ex_rs2_used));
      check("m_a_stall", a_stall, exp_stall(0));
      check("m_b_stall", b_stall, exp_stall(1));
      check("m_a_flush", a_flush, exp_flush());
      check("m_b_flush", b_flush, exp_flush());
      check("m_a_busy", a_mc_busy, m[0].busy);
      check("m_b_busy", b_mc_busy, m[1].busy);
      check("m_a_terr", a_terr, m[0].terr);
      check("m_b_terr", b_terr, m[1].terr);
      check("m_a_scnt", a_stall_count, m[0].sc);
      check("m_b_scnt", b_stall_count, m[1].sc);
      check("m_a_fcnt", a_flush_count, m[0].fc);
      check("m_b_fcnt", b_flush_count, m[1].fc);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_inputs();
    de_adr1 = '0; de_adr2 = '0; de_rd = '0; ex_adr1 = '0; ex_adr2 = '0; ex_rd = '0;
    mem_rd = '0; wb_rd = '0;
    de_rs1_used = 1'b0; de_rs2_used = 1'b0; de_regwrite = 1'b0; de_is_mc = 1'b0;
    ex_rs1_used = 1'b0; ex_rs2_used = 1'b0; ex_is_load = 1'b0; ex_mc_issue = 1'b0;
    mem_regwrite = 1'b0; wb_regwrite = 1'b0; mc_done = 1'b0; pc_source = 2'b00;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_a_busy"}, a_mc_busy, 0);
    check({tag, "_b_busy"}, b_mc_busy, 0);
    check({tag, "_a_terr"}, a_terr, 0);
    check({tag, "_b_terr"}, b_terr, 0);
    check({tag, "_a_scnt"}, a_stall_count, 0);
    check({tag, "_b_scnt"}, b_stall_count, 0);
    check({tag, "_a_fcnt"}, a_flush_count, 0);
    check({tag, "_b_fcnt"}, b_flush_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    RST_N = 1'b0;
    #12;
    check_cleared("rst");
    check("rst_stall", a_stall, 0);
    check("rst_fsel1", a_fsel1, 0);
    tick();
    RST_N = 1'b1;

    // Load-use
    tick(); ex_is_load = 1'b1; ex_rd = 5'd5; de_adr1 = 5'd5; de_rs1_used = 1'b1;
    sample(); check("lu_stall", a_stall, 1);
    tick(); ex_is_load = 1'b0; ex_rd = 5'd0;
    sample(); check("lu_release", a_stall, 0);
    tick(); ex_is_load = 1'b1; ex_rd = 5'd0; de_adr1 = 5'd0;
    sample(); check("lu_x0", a_stall, 0);
    tick(); clear_inputs();
    sample(); check("lu_cnt", a_stall_count, 1);

    // Forwarding
    tick(); mem_rd = 5'd7; wb_rd = 5'd7; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    ex_adr2 = 5'd7; ex_rs2_used = 1'b1;
    sample(); check("fwd_mem", a_fsel2, 1); check("fwd_other", a_fsel1, 0);
    tick(); mem_regwrite = 1'b0;
    sample(); check("fwd_wb", a_fsel2, 2);
    tick(); mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_adr2 = 5'd0;
    sample(); check("fwd_x0", a_fsel2, 0);
    tick(); mem_rd = 5'd7; ex_adr2 = 5'd7; ex_rs2_used = 1'b0; ex_adr1 = 5'd7; ex_rs1_used = 1'b1;
    sample(); check("fwd_unused", a_fsel2, 0); check("fwd_rs1", a_fsel1, 1);
    tick(); clear_inputs();

    // Multi-cycle RAW: DE reads x9 while the op is outstanding
    tick(); ex_mc_issue = 1'b1; ex_rd = 5'd9; de_adr1 = 5'd9; de_rs1_used = 1'b1;
    sample(); check("mc_issue_stall", a_stall, 0);
    tick(); ex_mc_issue = 1'b0; ex_rd = 5'd0;
    for (int i = 0; i < 10; i++) begin
      sample(); check("mc_raw_stall", a_stall, 1); check("mc_busy", a_mc_busy, 1);
      tick();
    end
    mc_done = 1'b1;
    sample(); check("mc_done_release", a_stall, 0);
    tick(); clear_inputs();
    sample(); check("mc_idle", a_mc_busy, 0); check("mc_stall_cnt", a_stall_count, 11);

    // Structural / WAW / flush override
    tick(); ex_mc_issue = 1'b1; ex_rd = 5'd12; de_is_mc = 1'b1;
    sample(); check("str_issue", a_stall, 1);
    tick(); ex_mc_issue = 1'b0; ex_rd = 5'd0;
    sample(); check("str_busy", a_stall, 1);
    tick(); de_is_mc = 1'b0; de_regwrite = 1'b1; de_rd = 5'd12;
    sample(); check("waw", a_stall, 1);
    tick(); pc_source = 2'b10;
    sample(); check("flush_no_stall", a_stall, 0); check("flush", a_flush, 1);
    check("flush_busy", a_mc_busy, 1);
    tick(); pc_source = 2'b00; de_regwrite = 1'b0; de_rd = 5'd0;
    sample(); check("busy_no_stall", a_stall, 0);
    tick(); mc_done = 1'b1; de_is_mc = 1'b1;
    sample(); check("str_done_release", a_stall, 0);
    tick(); clear_inputs();
    sample();
    check("s4_stall_cnt", a_stall_count, 14);
    check("s4_flush_cnt", a_flush_count, 1);
    check("s4_idle", a_mc_busy, 0);
    check("b_terr_sticky", b_terr, 1);

    // Synchronous-looking reset pulse to start the timeout run clean
    tick(); RST_N = 1'b0;
    #1; check_cleared("rst2");
    tick(); RST_N = 1'b1;

    // Timeout on the 4-cycle unit
    tick(); ex_mc_issue = 1'b1; ex_rd = 5'd3;
    sample(); check("tmo_issue", b_mc_busy, 0);
    tick(); ex_mc_issue = 1'b0; ex_rd = 5'd0;
    for (int i = 0; i < 4; i++) begin
      sample(); check("tmo_busy", b_mc_busy, 1); check("tmo_err_low", b_terr, 0);
      tick();
    end
    sample(); check("tmo_idle", b_mc_busy, 0); check("tmo_err", b_terr, 1);
    check("tmo_a_busy", a_mc_busy, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); sample(); check("tmo_sticky", b_terr, 1);
    end
    tick(); de_adr2 = 5'd3; de_rs2_used = 1'b1;
    sample(); check("pre_rst_raw", a_stall, 1); check("pre_rst_b", b_stall, 0);

    // Asynchronous reset mid-BUSY
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    check_cleared("arst");
    check("arst_stall", a_stall, 0);
    tick(); RST_N = 1'b1;
    tick(); clear_inputs();
    tick();
    sample();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
